// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding and
// 8N1 frame geometry.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;
  localparam int BIT_IDX_W  = 3;

  localparam logic [BIT_IDX_W-1:0] LAST_DATA_BIT = BIT_IDX_W'(DATA_BITS - 1);

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-write and serial-status bundle between a byte producer and the
// buffered UART transmitter.
interface uart_tx_fifo_if #(
  parameter int LEVEL_W = 5
);
  logic               tx_dv;
  logic [7:0]         tx_byte;
  logic               full;
  logic [LEVEL_W-1:0] level;
  logic               overflow;
  logic               tx_active;
  logic               tx_serial;
  logic               tx_done;

  modport master (
    output tx_dv, tx_byte,
    input  full, level, overflow, tx_active, tx_serial, tx_done
  );

  modport slave (
    input  tx_dv, tx_byte,
    output full, level, overflow, tx_active, tx_serial, tx_done
  );
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock byte FIFO with registered occupancy/full flags, a dropped-write
// pulse and a registered read port suitable for block RAM inference.
module sync_fifo #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int LEVEL_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               rd_en,
  output logic [WIDTH-1:0]   rd_data,
  output logic               full,
  output logic [LEVEL_W-1:0] level,
  output logic               overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [WIDTH-1:0]   rd_data_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [LEVEL_W-1:0] level_reg;
  logic [LEVEL_W-1:0] level_next;
  logic               full_reg;
  logic               overflow_reg;
  logic               push;
  logic               pop;

  // Writes are gated by the registered full flag, so a pop in the same
  // cycle never rescues a write that arrives while full.
  assign push = wr_en && !full_reg;
  assign pop  = rd_en && (level_reg != '0);

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      full_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg    <= level_next;
      full_reg     <= (level_next == LEVEL_W'(DEPTH));
      overflow_reg <= wr_en && full_reg;
    end
  end

  // Storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
    if (pop)  rd_data_reg <= mem[rd_ptr_reg];
  end

  assign rd_data  = rd_data_reg;
  assign full     = full_reg;
  assign level    = level_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are serialised
// LSB first, back-to-back while the FIFO stays non-empty.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter logic [15:0] CLKS_PER_BIT = 16'd100,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          LEVEL_W      = 5
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);

  logic [7:0]           fifo_rd_data;
  logic                 fifo_full;
  logic [LEVEL_W-1:0]   fifo_level;
  logic                 fifo_overflow;
  logic                 pop;

  tx_state_t            state_reg;
  tx_state_t            state_next;
  logic [15:0]          clk_cnt_reg;
  logic [15:0]          clk_cnt_next;
  logic [BIT_IDX_W-1:0] bit_idx_reg;
  logic [BIT_IDX_W-1:0] bit_idx_next;
  logic [7:0]           shift_reg;
  logic [7:0]           shift_next;
  logic                 load_reg;
  logic                 load_next;
  logic                 serial_reg;
  logic                 serial_next;
  logic                 active_reg;
  logic                 done_reg;
  logic                 done_next;
  logic                 bit_end;
  logic                 fifo_has_data;

  sync_fifo #(
    .WIDTH   (8),
    .DEPTH   (FIFO_DEPTH),
    .LEVEL_W (LEVEL_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.tx_dv),
    .wr_data  (bus.tx_byte),
    .rd_en    (pop),
    .rd_data  (fifo_rd_data),
    .full     (fifo_full),
    .level    (fifo_level),
    .overflow (fifo_overflow)
  );

  assign bit_end       = (clk_cnt_reg == CLKS_PER_BIT - 16'd1);
  assign fifo_has_data = (fifo_level != '0);

  always_comb begin
    state_next   = state_reg;
    clk_cnt_next = clk_cnt_reg + 16'd1;
    bit_idx_next = bit_idx_reg;
    pop          = 1'b0;
    load_next    = 1'b0;
    done_next    = 1'b0;
    // The FIFO read port is registered, so the popped byte lands one cycle
    // after the pop, i.e. in the first START cycle.
    shift_next   = load_reg ? fifo_rd_data : shift_reg;

    case (state_reg)
      ST_IDLE: begin
        clk_cnt_next = '0;
        if (fifo_has_data) begin
          pop        = 1'b1;
          load_next  = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          bit_idx_next = '0;
          state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          if (bit_idx_reg == LAST_DATA_BIT) begin
            state_next = ST_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          done_next    = 1'b1;
          if (fifo_has_data) begin
            pop        = 1'b1;
            load_next  = 1'b1;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        clk_cnt_next = '0;
        state_next   = ST_IDLE;
      end
    endcase

    // Line level is registered from the next state so the pin has no
    // combinational path.
    case (state_next)
      ST_START: serial_next = 1'b0;
      ST_DATA:  serial_next = shift_next[bit_idx_next];
      default:  serial_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      clk_cnt_reg <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      load_reg    <= 1'b0;
      serial_reg  <= 1'b1;
      active_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clk_cnt_reg <= clk_cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      load_reg    <= load_next;
      serial_reg  <= serial_next;
      active_reg  <= (state_next != ST_IDLE);
      done_reg    <= done_next;
    end
  end

  assign bus.full      = fifo_full;
  assign bus.level     = fifo_level;
  assign bus.overflow  = fifo_overflow;
  assign bus.tx_active = active_reg;
  assign bus.tx_serial = serial_reg;
  assign bus.tx_done   = done_reg;

endmodule
